// File: rtl/grant_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : grant_fifo
//  Purpose  : Small synchronous FIFO that captures the output of an upstream
//             one-hot priority mux. Each entry stores the selected data word
//             and the binary index of the grant bit that selected it. Illegal
//             or blocked grants raise a sticky drop_err flag.
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous active-low reset
//             in_data    - selected data from upstream mux (width bits)
//             in_grant   - one-hot grant vector (n bits), zero = idle
//             in_ready   - FIFO can accept a write
//             out_data   - head entry data (0 when empty)
//             out_src    - head entry source index (0 when empty)
//             out_valid  - head entry present
//             out_ready  - downstream accepts head entry
//             count      - occupancy 0..depth
//             drop_err   - sticky: a grant was presented but not stored
//  Revision : 1.0 - initial release
// ============================================================================
module grant_fifo #(
   parameter int width = 4,
   parameter int n     = 4,
   parameter int depth = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [width-1:0]           in_data,
   input  logic [n-1:0]               in_grant,
   output logic                       in_ready,
   output logic [width-1:0]           out_data,
   output logic [((n > 1) ? $clog2(n) : 1)-1:0] out_src,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(depth):0]     count,
   output logic                       drop_err
);

   localparam int srcw = (n > 1) ? $clog2(n) : 1;
   localparam int AW   = $clog2(depth);
   localparam int CW   = AW + 1;

   // Storage: contents are never reset; the occupancy count alone decides
   // what is valid, and the head outputs are masked while empty.
   logic [width-1:0] data_q [depth];
   logic [srcw-1:0]  src_q  [depth];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             drop_err_q, drop_err_d;

   logic             grant_any;
   logic             grant_onehot;
   logic [srcw-1:0]  grant_idx;
   logic             push;
   logic             pop;
   logic             empty;
   logic             full;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(depth));

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign grant_any    = |in_grant;
   assign grant_onehot = grant_any && ((in_grant & (in_grant - 1'b1)) == '0);

   // One-hot to binary. OR-ing indices is exact for a one-hot vector; the
   // result is only used when grant_onehot holds.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < n; i++) begin
         if (in_grant[i]) begin
            grant_idx = grant_idx | srcw'(i);
         end
      end
   end

   assign push = grant_onehot && !full;
   assign pop  = !empty && out_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_err_d = drop_err_q;

      // Pointers wrap naturally because depth is a power of two.
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Any grant activity that does not result in a write is a drop.
      if (grant_any && !push) begin
         drop_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_err_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_err_q <= drop_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr_q] <= in_data;
         src_q[wr_ptr_q]  <= grant_idx;
      end
   end

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign out_data  = empty ? '0 : data_q[rd_ptr_q];
   assign out_src   = empty ? '0 : src_q[rd_ptr_q];
   assign count     = count_q;
   assign drop_err  = drop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_grant_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grant_fifo
//  Purpose  : Directed self-checking bench for grant_fifo (width=4, n=4,
//             depth=4) with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grant_fifo;

   logic       clk;
   logic       rst_n;
   logic [3:0] in_data;
   logic [3:0] in_grant;
   logic       in_ready;
   logic [3:0] out_data;
   logic [1:0] out_src;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] count;
   logic       drop_err;

   int n_pass = 0;
   int n_total = 0;

   grant_fifo #(.width(4), .n(4), .depth(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_grant  (in_grant),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .drop_err  (drop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit
   // after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_data   = 4'h0;
      in_grant  = 4'h0;
      out_ready = 1'b0;
      #3;
      // Reset state, before any clock edge
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_drop_err", drop_err, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      tick();
      #2 rst_n = 1'b1;
      tick();

      // Single push from requester 2
      in_grant = 4'b0100; in_data = 4'hA;
      tick();
      in_grant = 4'b0000; in_data = 4'hF;
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 10);
      chk("single_src", out_src, 2);
      chk("single_count", count, 1);
      // Held while not accepted; in_data ignored with grant zero
      tick();
      chk("hold_data", out_data, 10);
      chk("hold_count", count, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pop_count", count, 0);
      chk("pop_valid", out_valid, 0);
      chk("empty_data_zero", out_data, 0);

      // Wrap: 10 back-to-back push/pop pairs
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_grant = 4'(1 << (i % 4));
         in_data  = 4'(i);
         tick();
         chk("wrap_data", out_data, i);
         chk("wrap_src", out_src, i % 4);
         chk("wrap_count", count, 1);
      end
      in_grant = 4'b0000;
      tick();
      out_ready = 1'b0;
      chk("wrap_end_count", count, 0);
      chk("wrap_no_drop", drop_err, 0);

      // Simultaneous push/pop at count=2
      in_grant = 4'b0001; in_data = 4'h7;
      tick();
      in_grant = 4'b0010; in_data = 4'h8;
      tick();
      chk("pp_pre_count", count, 2);
      in_grant = 4'b1000; in_data = 4'h9; out_ready = 1'b1;
      tick();
      in_grant = 4'b0000;
      chk("pp_count", count, 2);
      chk("pp_head_data", out_data, 8);
      chk("pp_head_src", out_src, 1);
      tick();
      chk("pp_last_data", out_data, 9);
      chk("pp_last_src", out_src, 3);
      chk("pp_last_count", count, 1);
      tick();
      out_ready = 1'b0;
      chk("pp_drained", count, 0);

      // Fill with sources 0..3, data 1..4
      for (int k = 0; k < 4; k++) begin
         in_grant = 4'(1 << k);
         in_data  = 4'(k + 1);
         tick();
      end
      chk("fill_count", count, 4);
      chk("fill_in_ready", in_ready, 0);
      chk("fill_no_drop", drop_err, 0);
      in_grant = 4'b0001; in_data = 4'h5;
      tick();
      in_grant = 4'b0000;
      chk("full_drop_err", drop_err, 1);
      chk("full_count", count, 4);
      // Full with simultaneous pop: push still blocked
      in_grant = 4'b0010; in_data = 4'hC; out_ready = 1'b1;
      tick();
      in_grant = 4'b0000; out_ready = 1'b0;
      chk("full_pop_count", count, 3);
      chk("full_pop_head", out_data, 2);
      // Drain remaining 2,3,4
      out_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         chk("drain_data", out_data, k + 1);
         chk("drain_src", out_src, k);
         tick();
      end
      out_ready = 1'b0;
      chk("drain_count", count, 0);
      chk("drop_sticky", drop_err, 1);

      // Reset mid-operation at count=3
      for (int k = 0; k < 3; k++) begin
         in_grant = 4'b0100; in_data = 4'(k + 11);
         tick();
      end
      in_grant = 4'b0000;
      chk("pre_rst_count", count, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_drop", drop_err, 0);
      chk("mid_rst_data", out_data, 0);
      tick();
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_count", count, 0);

      // Resume after reset
      in_grant = 4'b1000; in_data = 4'h6;
      tick();
      in_grant = 4'b0000;
      chk("resume_data", out_data, 6);
      chk("resume_src", out_src, 3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("resume_empty", count, 0);

      // Illegal grant while empty
      in_grant = 4'b0110; in_data = 4'h3;
      tick();
      in_grant = 4'b0000;
      chk("illegal_count", count, 0);
      chk("illegal_drop", drop_err, 1);
      chk("illegal_valid", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/grant_fifo.md
GRANT_FIFO -- requirements
Module: grant_fifo

Interface
REQ-001 SHALL have parameter width, default 4: data bits per requester.
REQ-002 SHALL have parameter n, default 4: number of requesters (grant vector width), n >= 2.
REQ-003 SHALL have parameter depth, default 4: number of entries, a power of 2, depth >= 2.
REQ-004 SHALL define local srcw = ceil(log2(n)), minimum 1.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_data  input  width  selected data from the upstream priority mux.
REQ-009 in_grant  input  n  one-hot grant from the upstream mux; all-zero means no transfer.
REQ-010 in_ready  output  1  high when the FIFO can accept a write.
REQ-011 out_data  output  width  head entry data.
REQ-012 out_src  output  srcw  binary index of the grant bit that wrote the head entry.
REQ-013 out_valid  output  1  head entry present.
REQ-014 out_ready  input  1  downstream accepts the head entry.
REQ-015 count  output  ceil(log2(depth))+1  current occupancy, 0..depth.
REQ-016 drop_err  output  1  sticky flag: a grant was presented but not stored.

Function
REQ-017 SHALL drive in_ready = (count != depth), combinationally from registered state only.
REQ-018 SHALL push when in_grant is exactly one-hot and in_ready = 1.
- Stores in_data plus the binary index of the set grant bit at the write pointer.
REQ-019 SHALL pop when out_valid = 1 and out_ready = 1.
- Advances the read pointer.
REQ-020 SHALL drive out_valid = (count != 0).
REQ-021 SHALL force out_data and out_src to 0 while count = 0.
REQ-022 SHALL keep out_data and out_src stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL present an entry pushed at edge T on out_data/out_src/out_valid after edge T.
- One-cycle latency; no combinational pass-through from in_data to out_data.
REQ-024 SHALL, on simultaneous push and pop, perform both and leave count unchanged.
- Applies at any occupancy from 1 to depth-1.
- When full, push is blocked (in_ready = 0) even if a pop occurs in the same cycle.
REQ-025 SHALL increment count on push only, decrement on pop only, and never exceed depth or go below 0.
REQ-026 SHALL wrap read and write pointers modulo depth.
REQ-027 SHALL set drop_err on any edge where in_grant != 0 and either in_ready = 0 or in_grant is not one-hot.
- No write occurs in that cycle.
- drop_err is cleared only by reset.
REQ-028 SHALL ignore in_data whenever in_grant = 0.
REQ-029 SHALL preserve FIFO order of entries regardless of source index.

Reset
REQ-030 SHALL, while rst_n = 0 and independent of clk, force:
- count, both pointers, out_valid and drop_err to 0;
- out_data and out_src to 0;
- in_ready to 1.
REQ-031 SHALL discard all stored entries on reset, including a reset asserted mid-operation.
REQ-032 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-033 Single push: width=4, n=4, in_grant=4'b0100, in_data=4'hA for one cycle, out_ready=0 -> next cycle out_valid=1, out_data=4'hA, out_src=2, count=1.
REQ-034 Fill: 4 pushes, sources 0,1,2,3, data 1,2,3,4, out_ready=0 -> count=4, in_ready=0.
- A fifth grant of 4'b0001 -> drop_err=1, count stays 4.
- Draining then yields data 1,2,3,4 with out_src 0,1,2,3.
REQ-035 Simultaneous push/pop at count=2, out_ready=1, in_grant=4'b1000 -> count stays 2, head advances, new entry lands last.
REQ-036 Illegal grant 4'b0110 while empty -> no write, count=0, drop_err=1.
REQ-037 Wrap: 10 push/pop pairs through depth=4 with data 0..9 -> output order 0..9, no drop_err.
REQ-038 Reset mid-operation: count=3, pull rst_n low between clock edges -> immediately out_valid=0, count=0, in_ready=1, drop_err=0.
